soc_system_hex_sequencer: RTL and testbench
===========================================

# soc_system_hex_sequencer

Write sequencer for the bank of seven-segment HEX PIO slaves in the SoC system. It accepts a packed hexadecimal value through a valid/ready request handshake and converts each nibble to an active-low segment pattern. It then performs one Avalon-MM write per digit to the matching HEX PIO (data register, address 0) and pulses `done` when the bank is updated. Optional leading-zero blanking writes the all-off pattern to unused high digits.

## Interface
- `NUM_DIGITS`, 6: number of HEX PIO slaves driven; legal range 1..8.
- `WRITE_GAP`, 0: idle cycles inserted between consecutive digit writes; legal range 0..15.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request (high only in IDLE).
- `req_value`  in  4*NUM_DIGITS  packed value; nibble i drives digit i (digit 0 = least significant).
- `req_blank_lz`  in  1  blank leading zero digits for this request.
- `hex_chipselect`  out  NUM_DIGITS  one-hot chipselect; bit i selects HEX PIO i.
- `hex_address`  out  2  PIO register address; constant 0.
- `hex_write_n`  out  1  active-low write strobe.
- `hex_writedata`  out  32  write data, {25'b0, seg[6:0]}.
- `done`  out  1  one-cycle pulse after the last digit write of a request.

## Operation
- States: IDLE, WRITE, GAP, DONE.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `req_value` and `req_blank_lz`, clear digit index, go to WRITE.
- WRITE: lasts exactly 1 cycle.
  - Drives `hex_chipselect`=1<<idx, `hex_write_n`=0, `hex_writedata`={25'b0, seg(idx)}.
  - If idx==NUM_DIGITS-1, go to DONE.
  - Else increment idx and go to GAP if WRITE_GAP>0, otherwise stay in WRITE.
- GAP: outputs idle; counts WRITE_GAP cycles, then goes to WRITE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- Idle outputs (every state except WRITE): `hex_chipselect`=0, `hex_write_n`=1, `hex_writedata`=0. `hex_address` is always 0.
- The PIO has no waitrequest, so every write completes in its single cycle.
- Segment code is active-low, bit0=a … bit6=g:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Blank pattern is 7'h7F.
- Leading-zero blanking: when the latched blank flag is set, digit i is blanked iff every nibble from i up to NUM_DIGITS-1 is zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Writes are issued from digit 0 upward. The request value is latched at accept; `req_value` changes during a sequence have no effect.
- A request held valid while busy waits, since `req_ready`=0 outside IDLE. Sequences never overlap or interleave.
- Width rules:
  - digit index: 3 bits
  - gap counter: 4 bits
  - `hex_writedata`[31:7] always 0

## Timing
- Reset values: `req_ready`=1, `hex_chipselect`=0, `hex_address`=0, `hex_write_n`=1, `hex_writedata`=0, `done`=0; state IDLE.
- Accept at rising edge k. Digit i write is driven in cycle k+1+i*(WRITE_GAP+1).
- `done` is high in the cycle after the last write, i.e. cycle k+1+(NUM_DIGITS-1)*(WRITE_GAP+1)+1.
- `req_ready` returns to 1 in the cycle after `done`. Minimum request-to-request spacing is NUM_DIGITS+2 cycles at WRITE_GAP=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from request inputs to the `hex_*` outputs.
- Reset asserted mid-sequence: all outputs go to reset values immediately (asynchronous) and no further writes occur after release. The PIOs share `reset_n` and return to 7'h7F.
- NUM_DIGITS=1: a single WRITE cycle, then DONE; the GAP state is never entered.

## Test plan
- NUM_DIGITS=6, GAP=0, value 24'h012345, blank=0, accepted at edge 0 -> writes in cycles 1..6 to cs 01,02,04,08,10,20 with data 12,19,30,24,79,40; `done` in cycle 7; `req_ready`=1 in cycle 8.
- Value 24'h00000F, blank=1 -> digit0 data 0E; digits 1..5 data 7F.
- Value 24'h000000, blank=1 -> digit0 data 40, others 7F. Same value with blank=0 -> all six data 40.
- `req_valid` held continuously with two values 24'hABCDEF then 24'h000001 -> second accepted only after `done`. Digit writes never overlap; digit0 of the second request carries data 79.
- GAP=2 -> chipselect pulses every 3 cycles, each 1 cycle wide; `done` in cycle 17.
- `reset_n` low after the third write -> `hex_write_n`=1 and `hex_chipselect`=0 at once. After release: `req_ready`=1, no writes until a new request.

Source files
------------

// File: rtl/soc_system_hex_sequencer_if.sv
// ---------------------------------------------------------------------------
// soc_system_hex_sequencer_if
//
// Purpose: bundles the request handshake and the Avalon-MM write bus that
// connect the HEX sequencer to its requester and to the HEX PIO bank.
//
// Signals:
//   req_valid      requester -> sequencer  request present
//   req_ready      sequencer -> requester  sequencer idle and able to accept
//   req_value      requester -> sequencer  packed value, nibble i = digit i
//   req_blank_lz   requester -> sequencer  blank leading zero digits
//   hex_chipselect sequencer -> PIOs       one-hot select, bit i = HEX PIO i
//   hex_address    sequencer -> PIOs       PIO register address (always 0)
//   hex_write_n    sequencer -> PIOs       active-low write strobe
//   hex_writedata  sequencer -> PIOs       {25'b0, seg[6:0]}
//   done           sequencer -> requester  one-cycle pulse when bank updated
//
// Modports:
//   master  requester / system side
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface soc_system_hex_sequencer_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      req_valid;
    logic                      req_ready;
    logic [4*NUM_DIGITS-1:0]   req_value;
    logic                      req_blank_lz;
    logic [NUM_DIGITS-1:0]     hex_chipselect;
    logic [1:0]                hex_address;
    logic                      hex_write_n;
    logic [31:0]               hex_writedata;
    logic                      done;

    modport master (
        output req_valid,
        output req_value,
        output req_blank_lz,
        input  req_ready,
        input  hex_chipselect,
        input  hex_address,
        input  hex_write_n,
        input  hex_writedata,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_value,
        input  req_blank_lz,
        output req_ready,
        output hex_chipselect,
        output hex_address,
        output hex_write_n,
        output hex_writedata,
        output done
    );
endinterface

// File: rtl/soc_system_hex_sequencer.sv
// ---------------------------------------------------------------------------
// soc_system_hex_sequencer
//
// Purpose: accepts a packed hexadecimal value, converts each nibble to an
// active-low seven-segment pattern (bit0 = a ... bit6 = g) and writes one
// pattern per digit to the data register of the matching HEX PIO, from
// digit 0 upward. Optionally blanks leading zero digits. Pulses done once
// the whole bank has been written.
//
// Parameters:
//   NUM_DIGITS  number of HEX PIO slaves driven (1..8)
//   WRITE_GAP   idle cycles inserted between consecutive digit writes (0..15)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      request handshake + Avalon-MM write bus (slave modport)
// ---------------------------------------------------------------------------
module soc_system_hex_sequencer #(
    parameter int NUM_DIGITS = 6,
    parameter int WRITE_GAP  = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    soc_system_hex_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    // Only meaningful when WRITE_GAP > 0; the GAP state is unreachable otherwise.
    localparam logic [3:0] LAST_GAP = 4'(WRITE_GAP - 1);
    localparam logic [1:0] AFTER_WRITE = (WRITE_GAP > 0) ? ST_GAP : ST_WRITE;

    logic [1:0]               state;
    logic [2:0]               idx;
    logic [3:0]               gap_cnt;
    logic [4*NUM_DIGITS-1:0]  value_q;
    logic                     blank_q;

    logic [31:0]              value_ext;
    logic [7:0]               blank_mask;
    logic                     zero_above;
    logic [3:0]               nibble;
    logic [6:0]               seg;
    logic [NUM_DIGITS-1:0]    cs_dec;

    // Active-low seven-segment encoding, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Sequencer state. The request is latched at accept so that later
    // changes on req_value cannot disturb a sequence already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            gap_cnt <= 4'd0;
            value_q <= '0;
            blank_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        value_q <= bus.req_value;
                        blank_q <= bus.req_blank_lz;
                        idx     <= 3'd0;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx     <= idx + 3'd1;
                        gap_cnt <= 4'd0;
                        state   <= AFTER_WRITE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state <= ST_WRITE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Leading-zero mask: scan from the top digit down, digit i is blanked
    // while every nibble from i upward is zero. Digit 0 always shows.
    always_comb begin
        value_ext  = 32'(value_q);
        blank_mask = 8'h00;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (value_ext[4*i +: 4] == 4'h0);
            if (i != 0) begin
                blank_mask[i] = blank_q && zero_above;
            end
        end
    end

    // Pattern for the digit currently being written.
    always_comb begin
        nibble = value_ext[{idx, 2'b00} +: 4];
        seg    = blank_mask[idx] ? 7'h7F : hex_to_seg(nibble);
    end

    // One-hot chipselect decoded from the registered index; zero outside WRITE.
    always_comb begin
        cs_dec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cs_dec[i] = (state == ST_WRITE) && (idx == 3'(i));
        end
    end

    assign bus.req_ready      = (state == ST_IDLE);
    assign bus.done           = (state == ST_DONE);
    assign bus.hex_address    = 2'b00;
    assign bus.hex_chipselect = cs_dec;
    assign bus.hex_write_n    = (state != ST_WRITE);
    assign bus.hex_writedata  = (state == ST_WRITE) ? {25'b0, seg} : 32'h0;

endmodule

// File: tb/tb_soc_system_hex_sequencer.sv
// ---------------------------------------------------------------------------
// tb_soc_system_hex_sequencer
//
// Purpose: directed self-checking bench for soc_system_hex_sequencer.
// dut0 runs with WRITE_GAP=0, dut1 with WRITE_GAP=2; both have six digits
// and share the clock and reset. Inputs change just after rising edges,
// outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_soc_system_hex_sequencer;

    logic clk;
    logic reset_n;

    int tests_run;
    int tests_failed;

    soc_system_hex_sequencer_if #(.NUM_DIGITS(6)) bus0 ();
    soc_system_hex_sequencer_if #(.NUM_DIGITS(6)) bus1 ();

    soc_system_hex_sequencer #(.NUM_DIGITS(6), .WRITE_GAP(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    soc_system_hex_sequencer #(.NUM_DIGITS(6), .WRITE_GAP(2)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and every failure.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request to dut0 and release valid right after it is taken.
    task automatic apply_stimulus(input logic [23:0] value, input logic blank);
        @(negedge clk);
        check_output("ready_before_req", 32'(bus0.req_ready), 32'd1);
        bus0.req_valid    = 1'b1;
        bus0.req_value    = value;
        bus0.req_blank_lz = blank;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
    endtask

    // Follow a dut0 sequence accepted at the previous rising edge: six
    // writes (packed expected patterns, digit 0 in the low bits), then done,
    // then ready again.
    task automatic check_sequence(input string tag, input logic [41:0] exp_seg);
        logic [5:0] cs_exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cs_exp = 6'b000001 << i;
            check_output({tag, "_cs"},    32'(bus0.hex_chipselect), 32'(cs_exp));
            check_output({tag, "_wn"},    32'(bus0.hex_write_n),    32'd0);
            check_output({tag, "_data"},  bus0.hex_writedata,       {25'b0, exp_seg[7*i +: 7]});
            check_output({tag, "_addr"},  32'(bus0.hex_address),    32'd0);
            check_output({tag, "_rdy"},   32'(bus0.req_ready),      32'd0);
            check_output({tag, "_done"},  32'(bus0.done),           32'd0);
        end
        @(negedge clk);
        check_output({tag, "_done_pulse"}, 32'(bus0.done),           32'd1);
        check_output({tag, "_done_cs"},    32'(bus0.hex_chipselect), 32'd0);
        check_output({tag, "_done_wn"},    32'(bus0.hex_write_n),    32'd1);
        check_output({tag, "_done_data"},  bus0.hex_writedata,       32'd0);
        check_output({tag, "_done_rdy"},   32'(bus0.req_ready),      32'd0);
        @(negedge clk);
        check_output({tag, "_end_rdy"},    32'(bus0.req_ready),      32'd1);
        check_output({tag, "_end_done"},   32'(bus0.done),           32'd0);
    endtask

    initial begin
        logic [5:0] cs_exp;
        logic       wr_exp;
        tests_run    = 0;
        tests_failed = 0;

        bus0.req_valid = 1'b0; bus0.req_value = '0; bus0.req_blank_lz = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_value = '0; bus1.req_blank_lz = 1'b0;

        // Reset values.
        reset_n = 1'b0;
        #2;
        check_output("rst_ready", 32'(bus0.req_ready),      32'd1);
        check_output("rst_cs",    32'(bus0.hex_chipselect), 32'd0);
        check_output("rst_addr",  32'(bus0.hex_address),    32'd0);
        check_output("rst_wn",    32'(bus0.hex_write_n),    32'd1);
        check_output("rst_data",  bus0.hex_writedata,       32'd0);
        check_output("rst_done",  32'(bus0.done),           32'd0);
        check_output("rst1_ready", 32'(bus1.req_ready),     32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 012345, no blanking: 5,4,3,2,1,0.
        apply_stimulus(24'h012345, 1'b0);
        check_sequence("v012345", {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});

        // 00000F with blanking: F then five blanks.
        apply_stimulus(24'h00000F, 1'b1);
        check_sequence("v00000F_lz", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E});

        // Zero with blanking keeps a single "0".
        apply_stimulus(24'h000000, 1'b1);
        check_sequence("v0_lz", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Zero without blanking shows six zeros.
        apply_stimulus(24'h000000, 1'b0);
        check_sequence("v0_nolz", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

        // Interior zero stays visible; only the zeros above the 1 blank.
        apply_stimulus(24'h000105, 1'b1);
        check_sequence("v000105_lz", {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12});

        // Valid held high: second value waits for done, and changing
        // req_value mid-sequence does not affect the first sequence.
        @(negedge clk);
        bus0.req_valid    = 1'b1;
        bus0.req_value    = 24'hABCDEF;
        bus0.req_blank_lz = 1'b0;
        @(posedge clk);
        #1;
        bus0.req_value = 24'h000001;
        check_sequence("hold_first", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        check_sequence("hold_second", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79});

        // WRITE_GAP=2 on dut1: writes in cycles 1,4,...,16, done in 17.
        @(negedge clk);
        bus1.req_valid    = 1'b1;
        bus1.req_value    = 24'h012345;
        bus1.req_blank_lz = 1'b0;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            wr_exp = (c <= 16) && (((c - 1) % 3) == 0);
            cs_exp = wr_exp ? (6'b000001 << ((c - 1) / 3)) : 6'b000000;
            check_output("gap_cs", 32'(bus1.hex_chipselect), 32'(cs_exp));
            check_output("gap_wn", 32'(bus1.hex_write_n),    32'(!wr_exp));
            check_output("gap_done", 32'(bus1.done),         32'(c == 17));
            check_output("gap_ready", 32'(bus1.req_ready),   32'(c == 18));
            if (c == 1) check_output("gap_d0", bus1.hex_writedata, 32'h12);
            if (c == 4) check_output("gap_d1", bus1.hex_writedata, 32'h19);
            if (c == 16) check_output("gap_d5", bus1.hex_writedata, 32'h40);
            if (c == 2) check_output("gap_idle_data", bus1.hex_writedata, 32'h0);
        end

        // Reset during the fourth write: outputs drop at once, no writes after.
        apply_stimulus(24'h012345, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cs_exp = 6'b000001 << i;
            check_output("pre_rst_cs", 32'(bus0.hex_chipselect), 32'(cs_exp));
        end
        @(negedge clk);
        check_output("pre_rst_cs3", 32'(bus0.hex_chipselect), 32'h08);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("async_rst_cs",    32'(bus0.hex_chipselect), 32'd0);
        check_output("async_rst_wn",    32'(bus0.hex_write_n),    32'd1);
        check_output("async_rst_data",  bus0.hex_writedata,       32'd0);
        check_output("async_rst_ready", 32'(bus0.req_ready),      32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_output("post_rst_cs",    32'(bus0.hex_chipselect), 32'd0);
            check_output("post_rst_wn",    32'(bus0.hex_write_n),    32'd1);
            check_output("post_rst_ready", 32'(bus0.req_ready),      32'd1);
        end

        // Normal operation resumes after reset.
        apply_stimulus(24'hABCDEF, 1'b1);
        check_sequence("after_rst", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
